// File: rtl/gauss_column_fetch_pkg.sv
// Shared types and constants for the 9-tap column fetcher.
// Holds the FSM state encoding, the gauss_shift command codes and the tap count.
package gauss_column_fetch_pkg;

   localparam int TAPS  = 9;
   localparam int TAP_W = 4;

   localparam logic [1:0] GS_HOLD   = 2'b00;
   localparam logic [1:0] GS_SHIFT  = 2'b01;
   localparam logic [1:0] GS_NEWROW = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/gauss_column_fetch_addr_gen.sv
// Byte address of one tap: base + (row + tap) * IMG_W + col.
// All arithmetic is done at ADDR_W bits, so overflow wraps modulo 2^ADDR_W.
module fetch_addr_gen
   import gauss_column_fetch_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int ADDR_W = 19,
   parameter int ROW_W  = 9,
   parameter int COL_W  = 10
) (
   input  logic [ADDR_W-1:0] base,
   input  logic [ROW_W-1:0]  row,
   input  logic [TAP_W-1:0]  tap,
   input  logic [COL_W-1:0]  col,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] line;

   always_comb begin
      line = ADDR_W'(row) + ADDR_W'(tap);
      addr = base + line * ADDR_W'(IMG_W) + ADDR_W'(col);
   end

endmodule

// File: rtl/gauss_column_fetch.sv
// Fetches 9-pixel image columns from a request/grant SRAM port and presents them
// as taps A..I to a downstream 9x9 window, one column per nineXnine_enable strobe.
module gauss_column_fetch
   import gauss_column_fetch_pkg::*;
#(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              sram_ren,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic              sram_gnt,
   input  logic              sram_rvalid,
   input  logic [7:0]        sram_rdata,
   output logic [7:0]        sram_outA,
   output logic [7:0]        sram_outB,
   output logic [7:0]        sram_outC,
   output logic [7:0]        sram_outD,
   output logic [7:0]        sram_outE,
   output logic [7:0]        sram_outF,
   output logic [7:0]        sram_outG,
   output logic [7:0]        sram_outH,
   output logic [7:0]        sram_outI,
   output logic              nineXnine_enable,
   output logic [1:0]        gauss_shift,
   input  logic              win_ready,
   output logic              busy,
   output logic              frame_done,
   output logic [2:0]        fsm_state
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - TAPS);
   localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
   localparam logic [TAP_W-1:0] TAP_FULL = TAP_W'(TAPS);

   fetch_state_t      state;
   logic [ROW_W-1:0]  row;
   logic [COL_W-1:0]  col;
   logic [TAP_W-1:0]  tap;
   logic [TAP_W-1:0]  cap;
   logic [TAP_W-1:0]  issued;
   logic [TAP_W-1:0]  cap_next;
   logic [ADDR_W-1:0] base;
   logic [7:0]        taps [TAPS];
   logic              rd_take;

   fetch_addr_gen #(
      .IMG_W (IMG_W),
      .ADDR_W(ADDR_W),
      .ROW_W (ROW_W),
      .COL_W (COL_W)
   ) u_addr_gen (
      .base(base),
      .row (row),
      .tap (tap),
      .col (col),
      .addr(sram_addr)
   );

   // A response is only taken while requests (including one granted this cycle)
   // outnumber captures; this drops stray and post-reset rvalids.
   always_comb begin
      issued   = tap + TAP_W'(sram_ren & sram_gnt);
      rd_take  = sram_rvalid && (cap < issued);
      cap_next = cap + TAP_W'(rd_take);
   end

   assign sram_ren         = (state == ST_ISSUE);
   assign busy             = (state != ST_IDLE);
   assign frame_done       = (state == ST_DONE);
   assign fsm_state        = state;
   assign nineXnine_enable = (state == ST_PRESENT) && win_ready;
   assign gauss_shift      = !nineXnine_enable ? GS_HOLD :
                             (col == '0) ? GS_NEWROW : GS_SHIFT;

   assign sram_outA = taps[0];
   assign sram_outB = taps[1];
   assign sram_outC = taps[2];
   assign sram_outD = taps[3];
   assign sram_outE = taps[4];
   assign sram_outF = taps[5];
   assign sram_outG = taps[6];
   assign sram_outH = taps[7];
   assign sram_outI = taps[8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         row   <= '0;
         col   <= '0;
         tap   <= '0;
         cap   <= '0;
         base  <= '0;
         for (int i = 0; i < TAPS; i++) taps[i] <= '0;
      end else begin
         if (rd_take) taps[cap] <= sram_rdata;
         cap <= cap_next;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  row   <= '0;
                  col   <= '0;
                  tap   <= '0;
                  cap   <= '0;
                  base  <= base_addr;
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (sram_gnt) begin
                  tap <= tap + TAP_W'(1);
                  if (tap == TAP_LAST)
                     state <= (cap_next == TAP_FULL) ? ST_PRESENT : ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (cap_next == TAP_FULL) state <= ST_PRESENT;
            end
            ST_PRESENT: begin
               if (win_ready) begin
                  tap <= '0;
                  cap <= '0;
                  if (col != COL_LAST) begin
                     col   <= col + COL_W'(1);
                     state <= ST_ISSUE;
                  end else if (row != ROW_LAST) begin
                     col   <= '0;
                     row   <= row + ROW_W'(1);
                     state <= ST_ISSUE;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gauss_column_fetch.sv
// Directed bench for gauss_column_fetch on a 3x10 image: a modelled SRAM with
// configurable grant/latency, a column scoreboard and a one-line summary.
module tb_gauss_column_fetch;
   import gauss_column_fetch_pkg::*;

   localparam int W       = 3;
   localparam int H       = 10;
   localparam int AW      = 19;
   localparam int NSTROBE = W * (H - 8);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          sram_ren;
   logic [AW-1:0] sram_addr;
   logic          sram_gnt = 1'b0;
   logic          sram_rvalid = 1'b0;
   logic [7:0]    sram_rdata = '0;
   logic [7:0]    sram_outA, sram_outB, sram_outC, sram_outD, sram_outE;
   logic [7:0]    sram_outF, sram_outG, sram_outH, sram_outI;
   logic          nineXnine_enable;
   logic [1:0]    gauss_shift;
   logic          win_ready = 1'b0;
   logic          busy;
   logic          frame_done;
   logic [2:0]    fsm_state;

   gauss_column_fetch #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_gnt(sram_gnt),
      .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata),
      .sram_outA(sram_outA), .sram_outB(sram_outB), .sram_outC(sram_outC),
      .sram_outD(sram_outD), .sram_outE(sram_outE), .sram_outF(sram_outF),
      .sram_outG(sram_outG), .sram_outH(sram_outH), .sram_outI(sram_outI),
      .nineXnine_enable(nineXnine_enable), .gauss_shift(gauss_shift),
      .win_ready(win_ready), .busy(busy), .frame_done(frame_done),
      .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [73:0] got, input logic [73:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [7:0] pix(input logic [AW-1:0] a);
      return a[7:0] ^ {a[18:16], a[12:8]} ^ 8'h3C;
   endfunction

   // SRAM model: grants and responses change on the falling edge
   logic [AW-1:0] pend_a[$];
   int            pend_t[$];
   int            cyc = 0, lat_min = 0, lat_max = 0, n_grants = 0, max_out = 0;
   bit            gnt_rand = 1'b0, spur_en = 1'b0, wr_rand = 1'b0;

   always @(negedge clk) begin
      cyc++;
      sram_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_rand) win_ready = 1'($urandom_range(0, 1));
      if (sram_ren && sram_gnt) begin
         pend_a.push_back(sram_addr);
         pend_t.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
         n_grants++;
         if (pend_a.size() > max_out) max_out = pend_a.size();
      end
      sram_rvalid = 1'b0;
      sram_rdata  = '0;
      if (pend_a.size() > 0 && pend_t[0] <= cyc) begin
         sram_rvalid = 1'b1;
         sram_rdata  = pix(pend_a.pop_front());
         void'(pend_t.pop_front());
      end else if (spur_en && pend_a.size() == 0 && $urandom_range(0, 3) == 0) begin
         sram_rvalid = 1'b1;
         sram_rdata  = 8'hEE;
      end
   end

   // scoreboard: one {gauss_shift, A..I} entry per expected strobe
   logic [73:0] exp_q[$];
   logic [71:0] taps_now;
   int          strobes = 0, dones = 0, fs = 0, gs_err = 0, ren_err = 0, extra = 0;
   logic [7:0]  s4_a = '0;
   logic [1:0]  s4_gs = '0;

   assign taps_now = {sram_outA, sram_outB, sram_outC, sram_outD, sram_outE,
                      sram_outF, sram_outG, sram_outH, sram_outI};

   always @(negedge clk) begin
      #2;
      if (nineXnine_enable) begin
         if (exp_q.size() != 0) check($sformatf("strobe%0d", fs), {gauss_shift, taps_now}, exp_q.pop_front());
         else extra++;
         if (fs == 3) begin
            s4_a  = sram_outA;
            s4_gs = gauss_shift;
         end
         strobes++;
         fs++;
      end else if (gauss_shift != 2'b00) begin
         gs_err++;
      end
      if (frame_done) dones++;
      if (sram_ren && !busy) ren_err++;
   end

   // driver tasks
   task automatic load_expected(input logic [AW-1:0] base);
      logic [73:0] e;
      exp_q.delete();
      for (int r = 0; r <= H - 9; r++) begin
         for (int c = 0; c < W; c++) begin
            e[73:72] = (c == 0) ? 2'b10 : 2'b01;
            for (int k = 0; k < 9; k++) e[71 - 8*k -: 8] = pix(AW'(int'(base) + (r + k) * W + c));
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic pulse_start(input logic [AW-1:0] base);
      @(negedge clk);
      fs        = 0;
      base_addr = base;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_frame(input string tag, input int s0, input int d0);
      int n = 0;
      while (dones == d0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_in_time"}, 74'(n < 3000), 74'd1);
      repeat (3) @(negedge clk);
      check({tag, "_strobes"}, 74'(strobes - s0), 74'(NSTROBE));
      check({tag, "_one_done"}, 74'(dones - d0), 74'd1);
      check({tag, "_idle"}, 74'(busy), 74'd0);
      check({tag, "_exp_empty"}, 74'(exp_q.size()), 74'd0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ren"},   74'(sram_ren), 74'd0);
      check({tag, "_en"},    74'(nineXnine_enable), 74'd0);
      check({tag, "_busy"},  74'(busy), 74'd0);
      check({tag, "_done"},  74'(frame_done), 74'd0);
      check({tag, "_shift"}, 74'(gauss_shift), 74'd0);
      check({tag, "_addr"},  74'(sram_addr), 74'd0);
      check({tag, "_taps"},  74'(taps_now), 74'd0);
      check({tag, "_state"}, 74'(fsm_state), 74'd0);
   endtask

   initial begin
      int          s0, d0, n, s_err, r0;
      logic [73:0] e0;

      #1 rst = 1'b1;
      #11 check_reset("por");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // zero-latency SRAM, always granted, always ready
      win_ready = 1'b1;
      lat_min = 0; lat_max = 0;
      load_expected(19'h00100);
      s0 = strobes; d0 = dones;
      pulse_start(19'h00100);
      wait_frame("s1", s0, d0);
      check("s2_strobe4_shift", 74'(s4_gs), 74'(2'b10));
      check("s2_strobe4_tapA", 74'(s4_a), 74'(pix(19'h00103)));

      // random grants, 1-5 cycle latency, stray rvalids
      gnt_rand = 1'b1; spur_en = 1'b1;
      lat_min = 1; lat_max = 5;
      load_expected(19'h12345);
      s0 = strobes; d0 = dones;
      pulse_start(19'h12345);
      wait_frame("s3", s0, d0);

      // downstream stall while a column is held in PRESENT
      gnt_rand = 1'b0; spur_en = 1'b0;
      lat_min = 2; lat_max = 2;
      win_ready = 1'b0;
      load_expected(19'h00200);
      s0 = strobes; d0 = dones;
      pulse_start(19'h00200);
      n = 0;
      while (fsm_state != 3'(ST_PRESENT) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("s4_reached_present", 74'(n < 200), 74'd1);
      e0 = exp_q[0];
      s_err = 0; r0 = n_grants;
      repeat (20) begin
         @(negedge clk);
         #2;
         if (nineXnine_enable || sram_ren || taps_now != e0[71:0]) s_err++;
      end
      check("s4_stall_clean", 74'(s_err), 74'd0);
      check("s4_no_new_reads", 74'(n_grants - r0), 74'd0);
      check("s4_no_strobe", 74'(strobes - s0), 74'd0);
      @(negedge clk);
      win_ready = 1'b1;
      #2 check("s4_strobe_on_rise", 74'(nineXnine_enable), 74'd1);
      wait_frame("s4", s0, d0);

      // reset in the middle of ISSUE with reads still in flight
      lat_min = 4; lat_max = 4;
      exp_q.delete();
      r0 = n_grants;
      pulse_start(19'h00040);
      n = 0;
      while (n_grants - r0 < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      #3 rst = 1'b1;
      #1 check_reset("s5_mid");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (pend_a.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("s5_drained", 74'(n < 100), 74'd1);
      repeat (2) @(negedge clk);
      #2 check("s5_late_rvalid_ignored", 74'(taps_now), 74'd0);
      check("s5_still_idle", 74'(busy), 74'd0);
      lat_min = 1; lat_max = 3;
      load_expected(19'h00040);
      s0 = strobes; d0 = dones;
      pulse_start(19'h00040);
      wait_frame("s5", s0, d0);

      // start while busy is ignored; addresses wrap past 2^19
      gnt_rand = 1'b1; wr_rand = 1'b1;
      lat_min = 0; lat_max = 3;
      load_expected(19'h7FFFB);
      s0 = strobes; d0 = dones;
      pulse_start(19'h7FFFB);
      @(negedge clk);
      check("s6_busy", 74'(busy), 74'd1);
      base_addr = 19'h00000;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      wait_frame("s6", s0, d0);
      wr_rand = 1'b0; win_ready = 1'b1;
      repeat (10) @(negedge clk);
      check("s6_no_restart", 74'(dones - d0), 74'd1);

      check("hold_code_when_idle", 74'(gs_err), 74'd0);
      check("ren_only_when_busy", 74'(ren_err), 74'd0);
      check("max_outstanding_le9", 74'(max_out <= 9), 74'd1);
      check("no_extra_strobes", 74'(extra), 74'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
